// File: rtl/obs_ctrl_if.sv
// Obstacle controller bus: scan position and game controls in, obstacle bounds and status out.
interface obs_ctrl_if;
   logic [10:0] pix_x;
   logic [10:0] pix_y;
   logic        game_on;
   logic        hit;
   logic [10:0] x1;
   logic [10:0] x2;
   logic [10:0] y1;
   logic [10:0] y2;
   logic        obs_active;
   logic        passed;
   logic        frozen;
   logic [3:0]  speed;

   modport master (
      output pix_x, pix_y, game_on, hit,
      input  x1, x2, y1, y2, obs_active, passed, frozen, speed
   );

   modport slave (
      input  pix_x, pix_y, game_on, hit,
      output x1, x2, y1, y2, obs_active, passed, frozen, speed
   );
endinterface

// File: rtl/obs_ctrl.sv
// Falling obstacle sequencer: spawns at a pseudo-random X, drops 'speed' lines per frame, freezes on hit.
// Bounds update one clk after the frame tick, with no backpressure. OBS_SPEEDUP_EN adds speed ramping on passes.
module obs_ctrl #(
   parameter int          MAX_X         = 640,
   parameter int          MAX_Y         = 480,
   parameter int          OBS_W         = 32,
   parameter int          OBS_H         = 16,
   parameter int          INIT_SPEED    = 1,
   parameter int          MAX_SPEED     = 8,
   parameter int          SPAWN_DELAY   = 30,
   parameter logic [9:0]  LFSR_SEED     = 10'h2A5,
   parameter int          SPEEDUP_EVERY = 4
) (
   input  logic     clk_i,
   input  logic     reset_i,
   obs_ctrl_if.slave bus
);

   localparam logic [10:0] PARK  = 11'h7FF;
   localparam logic [10:0] XSPAN = 11'(MAX_X - OBS_W);
   localparam int          CW    = $clog2(SPAWN_DELAY + 1);

   typedef enum logic [2:0] {IDLE, WAIT, SPAWN, FALL, HIT} state_t;

   state_t        state_q;
   logic          cond, cond_q, tick;
   logic [9:0]    lfsr_q, lfsr_d;
   logic [10:0]   lfsr_ext, xr;
   logic [10:0]   x1_q, x2_q, y1_q, y2_q;
   logic [11:0]   y_next;
   logic [CW-1:0] frame_cnt_q;
   logic          obs_active_q, passed_q, frozen_q;
   logic [3:0]    speed;

   // Edge-detect so a cond held for several clks yields one tick per frame
   assign cond     = (bus.pix_y == 11'(MAX_Y + 1)) && (bus.pix_x == 11'd0);
   assign tick     = cond & ~cond_q;
   assign lfsr_d   = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
   assign lfsr_ext = {1'b0, lfsr_q};
   assign xr       = (lfsr_ext >= XSPAN) ? (lfsr_ext - XSPAN) : lfsr_ext;
   assign y_next   = {1'b0, y1_q} + {8'd0, speed};

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cond_q <= 1'b0;
         lfsr_q <= LFSR_SEED;
      end else begin
         cond_q <= cond;
         lfsr_q <= lfsr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= IDLE;
         x1_q         <= PARK;
         x2_q         <= PARK;
         y1_q         <= PARK;
         y2_q         <= PARK;
         obs_active_q <= 1'b0;
         passed_q     <= 1'b0;
         frozen_q     <= 1'b0;
         frame_cnt_q  <= '0;
      end else begin
         passed_q <= 1'b0;
         if (!bus.game_on) begin
            state_q      <= IDLE;
            x1_q         <= PARK;
            x2_q         <= PARK;
            y1_q         <= PARK;
            y2_q         <= PARK;
            obs_active_q <= 1'b0;
            frozen_q     <= 1'b0;
            frame_cnt_q  <= '0;
         end else begin
            case (state_q)
               IDLE: begin
                  state_q     <= WAIT;
                  frame_cnt_q <= '0;
               end
               WAIT: begin
                  if (tick) begin
                     frame_cnt_q <= frame_cnt_q + CW'(1);
                     if (frame_cnt_q == CW'(SPAWN_DELAY - 1))
                        state_q <= SPAWN;
                  end
               end
               SPAWN: begin
                  x1_q         <= xr;
                  x2_q         <= xr + 11'(OBS_W - 1);
                  y1_q         <= 11'd0;
                  y2_q         <= 11'(OBS_H - 1);
                  obs_active_q <= 1'b1;
                  state_q      <= FALL;
               end
               FALL: begin
                  // A hit on the tick clk wins: no move and no pass pulse
                  if (bus.hit) begin
                     frozen_q <= 1'b1;
                     state_q  <= HIT;
                  end else if (tick) begin
                     if (y_next >= 12'(MAX_Y)) begin
                        passed_q     <= 1'b1;
                        x1_q         <= PARK;
                        x2_q         <= PARK;
                        y1_q         <= PARK;
                        y2_q         <= PARK;
                        obs_active_q <= 1'b0;
                        frame_cnt_q  <= '0;
                        state_q      <= WAIT;
                     end else begin
                        y1_q <= y_next[10:0];
                        y2_q <= y_next[10:0] + 11'(OBS_H - 1);
                     end
                  end
               end
               HIT: begin
                  state_q <= HIT;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

`ifdef OBS_SPEEDUP_EN
   logic [2:0] pass_cnt_q;
   logic [3:0] speed_q;

   always_ff @(posedge clk_i) begin
      if (reset_i || state_q == IDLE) begin
         pass_cnt_q <= 3'd0;
         speed_q    <= 4'(INIT_SPEED);
      end else if (passed_q) begin
         if (pass_cnt_q == 3'(SPEEDUP_EVERY - 1)) begin
            pass_cnt_q <= 3'd0;
            if (speed_q < 4'(MAX_SPEED))
               speed_q <= speed_q + 4'd1;
         end else begin
            pass_cnt_q <= pass_cnt_q + 3'd1;
         end
      end
   end

   assign speed = speed_q;
`else
   logic unused_cfg;
   assign unused_cfg = ^{4'(MAX_SPEED), 3'(SPEEDUP_EVERY)};
   assign speed      = 4'(INIT_SPEED);
`endif

   assign bus.x1         = x1_q;
   assign bus.x2         = x2_q;
   assign bus.y1         = y1_q;
   assign bus.y2         = y2_q;
   assign bus.obs_active = obs_active_q;
   assign bus.passed     = passed_q;
   assign bus.frozen     = frozen_q;
   assign bus.speed      = speed;

endmodule

// File: tb/tb_obs_ctrl.sv
// Directed bench for obs_ctrl: frames are synthesised by pulsing pix_y to MAX_Y+1 with pix_x=0.
module tb_obs_ctrl;
   logic clk = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;

   obs_ctrl_if bus ();

   obs_ctrl dut (
      .clk_i   (clk),
      .reset_i (reset),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic clk1();
      @(posedge clk);
      #1;
   endtask

   // hold = clks with the frame condition asserted, followed by one clk released
   task automatic frame(input int hold);
      bus.pix_x = 11'd0;
      bus.pix_y = 11'd481;
      repeat (hold) clk1();
      bus.pix_y = 11'd0;
      clk1();
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) frame(1);
   endtask

   task automatic run_until_pass(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 700 && !seen; i++) begin
         bus.pix_y = 11'd481;
         clk1();
         if (bus.passed === 1'b1) seen = 1'b1;
         bus.pix_y = 11'd0;
         clk1();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; bus.game_on = 1'b1; bus.hit = 1'b0;
      bus.pix_x = 11'd0; bus.pix_y = 11'd0;
      repeat (2) clk1();
      n_tests++; if (bus.x1 !== 11'h7FF) begin n_fail++; $display("FAIL reset_x1: got %h want 7ff", bus.x1); end
      n_tests++; if (bus.x2 !== 11'h7FF) begin n_fail++; $display("FAIL reset_x2: got %h want 7ff", bus.x2); end
      n_tests++; if (bus.y1 !== 11'h7FF) begin n_fail++; $display("FAIL reset_y1: got %h want 7ff", bus.y1); end
      n_tests++; if (bus.y2 !== 11'h7FF) begin n_fail++; $display("FAIL reset_y2: got %h want 7ff", bus.y2); end
      n_tests++; if (bus.obs_active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b want 0", bus.obs_active); end
      n_tests++; if (bus.passed !== 1'b0) begin n_fail++; $display("FAIL reset_passed: got %b want 0", bus.passed); end
      n_tests++; if (bus.frozen !== 1'b0) begin n_fail++; $display("FAIL reset_frozen: got %b want 0", bus.frozen); end
      n_tests++; if (bus.speed !== 4'd1) begin n_fail++; $display("FAIL reset_speed: got %0d want 1", bus.speed); end
      reset = 1'b0;
   endtask

   task automatic test_spawn();
      logic [10:0] diff;
      clk1();
      frames(29);
      n_tests++; if (bus.obs_active !== 1'b0) begin n_fail++; $display("FAIL early_spawn: active %b want 0", bus.obs_active); end
      frame(1);
      diff = bus.x2 - bus.x1;
      n_tests++; if (bus.obs_active !== 1'b1) begin n_fail++; $display("FAIL spawn_active: got %b want 1", bus.obs_active); end
      n_tests++; if (bus.y1 !== 11'd0) begin n_fail++; $display("FAIL spawn_y1: got %0d want 0", bus.y1); end
      n_tests++; if (bus.y2 !== 11'd15) begin n_fail++; $display("FAIL spawn_y2: got %0d want 15", bus.y2); end
      n_tests++; if (diff !== 11'd31) begin n_fail++; $display("FAIL spawn_width: got %0d want 31", diff); end
      n_tests++; if (!(bus.x1 < 11'd608)) begin n_fail++; $display("FAIL spawn_x1_range: got %0d want <608", bus.x1); end
      frame(1);
      n_tests++; if (bus.y1 !== 11'd1) begin n_fail++; $display("FAIL first_move_y1: got %0d want 1", bus.y1); end
      n_tests++; if (bus.y2 !== 11'd16) begin n_fail++; $display("FAIL first_move_y2: got %0d want 16", bus.y2); end
   endtask

   task automatic test_held_cond();
      for (int i = 0; i < 3; i++) begin
         frame(4);
         n_tests++;
         if (bus.y1 !== 11'(2 + i)) begin n_fail++; $display("FAIL held_cond_y1: got %0d want %0d", bus.y1, 2 + i); end
      end
   endtask

   task automatic test_pass();
      frames(475);
      n_tests++; if (bus.y1 !== 11'd479) begin n_fail++; $display("FAIL pre_exit_y1: got %0d want 479", bus.y1); end
      n_tests++; if (bus.passed !== 1'b0) begin n_fail++; $display("FAIL pre_exit_passed: got %b want 0", bus.passed); end
      bus.pix_y = 11'd481;
      clk1();
      n_tests++; if (bus.passed !== 1'b1) begin n_fail++; $display("FAIL exit_passed: got %b want 1", bus.passed); end
      n_tests++; if (bus.y1 !== 11'h7FF) begin n_fail++; $display("FAIL exit_park_y1: got %h want 7ff", bus.y1); end
      n_tests++; if (bus.x1 !== 11'h7FF) begin n_fail++; $display("FAIL exit_park_x1: got %h want 7ff", bus.x1); end
      n_tests++; if (bus.obs_active !== 1'b0) begin n_fail++; $display("FAIL exit_active: got %b want 0", bus.obs_active); end
      bus.pix_y = 11'd0;
      clk1();
      n_tests++; if (bus.passed !== 1'b0) begin n_fail++; $display("FAIL passed_width: got %b want 0", bus.passed); end
      frames(29);
      n_tests++; if (bus.obs_active !== 1'b0) begin n_fail++; $display("FAIL rewait_early: active %b want 0", bus.obs_active); end
      frame(1);
      n_tests++; if (bus.obs_active !== 1'b1) begin n_fail++; $display("FAIL respawn_active: got %b want 1", bus.obs_active); end
      n_tests++; if (bus.y1 !== 11'd0) begin n_fail++; $display("FAIL respawn_y1: got %0d want 0", bus.y1); end
   endtask

   task automatic test_hit_freeze();
      frames(100);
      n_tests++; if (bus.y1 !== 11'd100) begin n_fail++; $display("FAIL pre_hit_y1: got %0d want 100", bus.y1); end
      bus.pix_y = 11'd481; bus.hit = 1'b1;
      clk1();
      bus.hit = 1'b0;
      n_tests++; if (bus.y1 !== 11'd100) begin n_fail++; $display("FAIL hit_tick_y1: got %0d want 100", bus.y1); end
      n_tests++; if (bus.frozen !== 1'b1) begin n_fail++; $display("FAIL hit_frozen: got %b want 1", bus.frozen); end
      n_tests++; if (bus.passed !== 1'b0) begin n_fail++; $display("FAIL hit_passed: got %b want 0", bus.passed); end
      bus.pix_y = 11'd0;
      clk1();
      frames(5);
      n_tests++; if (bus.y1 !== 11'd100) begin n_fail++; $display("FAIL frozen_hold_y1: got %0d want 100", bus.y1); end
      n_tests++; if (bus.obs_active !== 1'b1) begin n_fail++; $display("FAIL frozen_active: got %b want 1", bus.obs_active); end
      bus.game_on = 1'b0;
      clk1();
      n_tests++; if (bus.x1 !== 11'h7FF) begin n_fail++; $display("FAIL idle_park_x1: got %h want 7ff", bus.x1); end
      n_tests++; if (bus.y2 !== 11'h7FF) begin n_fail++; $display("FAIL idle_park_y2: got %h want 7ff", bus.y2); end
      n_tests++; if (bus.frozen !== 1'b0) begin n_fail++; $display("FAIL idle_frozen: got %b want 0", bus.frozen); end
      n_tests++; if (bus.obs_active !== 1'b0) begin n_fail++; $display("FAIL idle_active: got %b want 0", bus.obs_active); end
   endtask

   task automatic test_hit_ignored();
      bus.game_on = 1'b1;
      clk1();
      bus.hit = 1'b1;
      frames(10);
      bus.hit = 1'b0;
      frames(20);
      n_tests++; if (bus.obs_active !== 1'b1) begin n_fail++; $display("FAIL wait_hit_active: got %b want 1", bus.obs_active); end
      n_tests++; if (bus.frozen !== 1'b0) begin n_fail++; $display("FAIL wait_hit_frozen: got %b want 0", bus.frozen); end
      n_tests++; if (bus.y1 !== 11'd0) begin n_fail++; $display("FAIL wait_hit_y1: got %0d want 0", bus.y1); end
   endtask

   task automatic test_speed();
      bit seen;
      int exp_speed;
      int n_pass;
`ifdef OBS_SPEEDUP_EN
      n_pass = 32;
`else
      n_pass = 4;
`endif
      reset = 1'b1; bus.game_on = 1'b1; bus.hit = 1'b0; bus.pix_y = 11'd0;
      repeat (2) clk1();
      reset = 1'b0;
      clk1();
      for (int p = 1; p <= n_pass; p++) begin
         run_until_pass(seen);
         if (!seen) begin
            n_tests++; n_fail++;
            $display("FAIL pass_timeout: pass %0d not seen within 700 frames", p);
            break;
         end
`ifdef OBS_SPEEDUP_EN
         exp_speed = 1 + p / 4;
         if (exp_speed > 8) exp_speed = 8;
         if (p == 3 || p == 4 || p == 28 || p == 32) begin
`else
         exp_speed = 1;
         if (p == 4) begin
`endif
            n_tests++;
            if (bus.speed !== 4'(exp_speed)) begin n_fail++; $display("FAIL speed_after_%0d: got %0d want %0d", p, bus.speed, exp_speed); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_spawn();
      test_held_cond();
      test_pass();
      test_hit_freeze();
      test_hit_ignored();
      test_speed();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
